systolic_skew_feeder: RTL

//  Operand transmitter for one edge of the PE array. Accepts one N-element FP32 row-vector per beat
//  (valid/ready) and drives N operand lanes, lane i delayed i+1 cycles, forming the diagonal wavefront
//  the PE_a/PE_b inputs need. Drains the skew with +0.0 (MAC-neutral), then pulses done.

---
 rtl/systolic_skew_feeder.sv | 119 +++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand skew feeder for one edge of a systolic PE array: accepts N-lane row vectors and
// emits them as a diagonal wavefront (lane i delayed i+1 cycles), draining with +0.0 before done.
module systolic_skew_feeder #(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_data,
    input  logic              in_last,
    output logic [N*DW-1:0]   lane_data,
    output logic [N-1:0]      lane_valid,
    output logic              done,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int unsigned FW = (N > 2) ? $clog2(N - 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [FW-1:0] flush_q;
    logic [FW-1:0] flush_d;
    logic          beat;

    // Ready depends only on state (and reset), never on in_valid
    always_comb begin
        in_ready = !rst && ((state_q == IDLE) || (state_q == STREAM));
    end

    assign beat = in_valid && in_ready;

    // Next-state: FLUSH lasts N-1 cycles so DONE lines up with the last element on lane N-1
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        case (state_q)
            IDLE, STREAM: begin
                if (beat) begin
                    if (in_last) begin
                        if (N > 1) begin
                            state_d = FLUSH;
                            flush_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == FW'(N - 2)) begin
                    state_d = DONE;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, done pulse and beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            flush_q  <= '0;
            done     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            done    <= (state_d == DONE);
            if (state_q == DONE) begin
                beat_cnt <= '0;
            end else if (beat && (beat_cnt != {CNT_W{1'b1}})) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Per-lane shift registers of depth i+1; non-beat cycles inject +0.0 / invalid
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [i:0][DW-1:0] d_q;
        logic [i:0]         v_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                d_q <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= beat ? in_data[i*DW +: DW] : '0;
                v_q[0] <= beat;
                for (int k = 1; k <= i; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign lane_data[i*DW +: DW] = d_q[i];
        assign lane_valid[i]         = v_q[i];
    end

endmodule
